max_tree_pipe: RTL

MAX_TREE_PIPE -- requirements
Module: max_tree_pipe

---
 rtl/max_tree_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/max_tree_pipe.sv
// max_tree_pipe: pipelined binary-tree signed max/min finder over M channels.
// Each tree level is one register stage, so a sample's result appears
// clog2(M) cycles after it is presented. Missing leaves (M not a power of
// two) are padded with a value that can never win.
// Optional running extremum across samples, enabled by defining the macro
// MAX_TREE_RUNNING_EN; without it the run_* outputs are tied to zero.
module max_tree_pipe #(
    parameter int N = 4,
    parameter int M = 4,
    localparam int L  = $clog2(M),
    localparam int IW = (L < 1) ? 1 : L
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    input  logic [M*N-1:0] in_data,
    input  logic           mode,
    input  logic           clear,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [IW-1:0]  out_index,
    output logic           run_valid,
    output logic [N-1:0]   run_data,
    output logic [IW-1:0]  run_index,
    output logic [7:0]     run_count
);

    // Leaf count rounded up to a power of two; the tree is stored heap-style:
    // node i has children 2i and 2i+1, root is node 1, leaves are P..2P-1.
    localparam int P = 1 << L;

    // Value that loses every comparison in the given mode (min for max, max for min).
    function automatic logic signed [N-1:0] neutral(input logic mn);
        return mn ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
    endfunction

    // True when b strictly beats a; ties favour a, which always holds the lower channels.
    function automatic logic better(input logic mn, input logic signed [N-1:0] a,
                                    input logic signed [N-1:0] b);
        return mn ? (b < a) : (b > a);
    endfunction

    // Registered tree nodes, per-depth valid and mode (depth 0 is the root).
    logic signed [N-1:0] node_dat [1:P-1];
    logic [IW-1:0]       node_idx [1:P-1];
    logic                vld      [0:L-1];
    logic                mode_p   [0:L-1];

    // Child-side view of the tree: registered nodes plus the input leaves.
    logic signed [N-1:0] src_dat  [2:2*P-1];
    logic [IW-1:0]       src_idx  [2:2*P-1];
    logic                vld_chain  [1:L];
    logic                mode_chain [1:L];
    logic signed [N-1:0] nxt_dat  [1:P-1];
    logic [IW-1:0]       nxt_idx  [1:P-1];

    // Gather children (input leaves or lower registers) and pick each node's winner.
    always_comb begin
        vld_chain[L]  = in_valid;
        mode_chain[L] = mode;
        for (int d = 1; d < L; d++) begin
            vld_chain[d]  = vld[d];
            mode_chain[d] = mode_p[d];
        end
        for (int i = 2; i < P; i++) begin
            src_dat[i] = node_dat[i];
            src_idx[i] = node_idx[i];
        end
        for (int k = 0; k < M; k++) begin
            src_dat[P+k] = in_data[k*N +: N];
            src_idx[P+k] = IW'(k);
        end
        for (int k = M; k < P; k++) begin
            src_dat[P+k] = neutral(mode);
            src_idx[P+k] = IW'(k);
        end
        for (int d = 0; d < L; d++) begin
            for (int j = 0; j < (1 << d); j++) begin
                if (better(mode_chain[d+1], src_dat[2*((1 << d) + j)],
                           src_dat[2*((1 << d) + j) + 1])) begin
                    nxt_dat[(1 << d) + j] = src_dat[2*((1 << d) + j) + 1];
                    nxt_idx[(1 << d) + j] = src_idx[2*((1 << d) + j) + 1];
                end else begin
                    nxt_dat[(1 << d) + j] = src_dat[2*((1 << d) + j)];
                    nxt_idx[(1 << d) + j] = src_idx[2*((1 << d) + j)];
                end
            end
        end
    end

    // Tree pipeline: valid always shifts, data and mode hold unless a sample arrives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < L; d++) begin
                vld[d]    <= 1'b0;
                mode_p[d] <= 1'b0;
            end
            for (int i = 1; i < P; i++) begin
                node_dat[i] <= '0;
                node_idx[i] <= '0;
            end
        end else begin
            for (int d = 0; d < L; d++) begin
                vld[d] <= vld_chain[d+1];
                if (vld_chain[d+1]) begin
                    mode_p[d] <= mode_chain[d+1];
                    for (int j = 0; j < (1 << d); j++) begin
                        node_dat[(1 << d) + j] <= nxt_dat[(1 << d) + j];
                        node_idx[(1 << d) + j] <= nxt_idx[(1 << d) + j];
                    end
                end
            end
        end
    end

    assign out_valid = vld[0];
    assign out_data  = node_dat[1];
    assign out_index = node_idx[1];

`ifdef MAX_TREE_RUNNING_EN
    // Running extremum: first result after reset/clear loads, later ones compete.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_valid <= 1'b0;
            run_data  <= '0;
            run_index <= '0;
            run_count <= 8'd0;
        end else if (out_valid) begin
            run_valid <= 1'b1;
            if (clear || !run_valid) begin
                run_data  <= out_data;
                run_index <= out_index;
                run_count <= 8'd1;
            end else begin
                if (better(mode_p[0], $signed(run_data), $signed(out_data))) begin
                    run_data  <= out_data;
                    run_index <= out_index;
                end
                if (run_count != 8'hFF) begin
                    run_count <= run_count + 8'd1;
                end
            end
        end else if (clear) begin
            run_valid <= 1'b0;
            run_count <= 8'd0;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = clear ^ mode_p[0];
    assign run_valid = 1'b0;
    assign run_data  = '0;
    assign run_index = '0;
    assign run_count = 8'd0;
`endif

endmodule
